// File: rtl/ni_packet_tx.sv
// Network-interface transmitter: serialises a send request plus payload words into a HEADER/BODY/TAIL wormhole packet.
// Optional NI_TX_STATS_EN adds saturating flit/stall counters. Flit = {type[1:0], payload[31:0]}, address = {x[3:0], y[3:0]}.
module ni_packet_tx #(
  parameter int X     = 1,
  parameter int Y     = 1,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_dst_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic [31:0]      data_i,
  output logic [33:0]      link_flit_o,
  output logic             link_enable_o,
  input  logic             link_ack_i,
  output logic             busy_o,
  output logic             err_self_o
`ifdef NI_TX_STATS_EN
  ,
  output logic [31:0]      stat_flits_o,
  output logic [31:0]      stat_stall_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_TAIL_LOAD,
    S_TAIL_WAIT,
    S_DRAIN
  } state_e;

  localparam logic [7:0]       SELF_ADDR = {4'(X), 4'(Y)};
  localparam logic [1:0]       FT_HEAD   = 2'b01;
  localparam logic [1:0]       FT_BODY   = 2'b10;
  localparam logic [1:0]       FT_TAIL   = 2'b11;
  localparam logic [LEN_W-1:0] ZERO      = '0;
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO       = LEN_W'(2);

  state_e           state_q;
  logic [33:0]      flit_q;
  logic             enable_q;
  logic [LEN_W-1:0] cnt_q;
  logic             err_q;
  logic             init_q;

  logic xfer, reg_free, req_ready, data_ready, req_fire, data_fire, req_self;

  always_comb begin
    xfer       = enable_q && link_ack_i;
    reg_free   = !enable_q || link_ack_i;
    req_ready  = init_q && ((state_q == S_IDLE) || (state_q == S_TAIL_WAIT && link_ack_i));
    data_ready = 1'b0;
    case (state_q)
      S_PAYLOAD:   data_ready = reg_free && (cnt_q > ONE);
      S_TAIL_LOAD: data_ready = reg_free && (cnt_q == ONE);
      S_DRAIN:     data_ready = (cnt_q != ZERO);
      default:     data_ready = 1'b0;
    endcase
    req_fire  = req_valid_i && req_ready;
    data_fire = data_valid_i && data_ready;
    req_self  = (req_dst_i == SELF_ADDR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      flit_q   <= '0;
      enable_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      err_q  <= req_fire && req_self;
      // A transferred flit frees the register; any load below re-asserts enable.
      if (xfer) enable_q <= 1'b0;
      case (state_q)
        S_IDLE, S_TAIL_WAIT: begin
          if (req_fire) begin
            cnt_q <= req_len_i;
            if (req_self) begin
              state_q <= (req_len_i == ZERO) ? S_IDLE : S_DRAIN;
            end else begin
              flit_q   <= {FT_HEAD, 24'h0, req_dst_i};
              enable_q <= 1'b1;
              state_q  <= (req_len_i <= ONE) ? S_TAIL_LOAD : S_PAYLOAD;
            end
          end else if (state_q == S_TAIL_WAIT && xfer) begin
            state_q <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (data_fire) begin
            flit_q   <= {FT_BODY, data_i};
            enable_q <= 1'b1;
            cnt_q    <= cnt_q - ONE;
            if (cnt_q == TWO) state_q <= S_TAIL_LOAD;
          end else if (cnt_q <= ONE) begin
            state_q <= S_TAIL_LOAD;
          end
        end
        S_TAIL_LOAD: begin
          if (cnt_q == ZERO) begin
            if (reg_free) begin
              flit_q   <= {FT_TAIL, 32'h0};
              enable_q <= 1'b1;
              state_q  <= S_TAIL_WAIT;
            end
          end else if (data_fire) begin
            flit_q   <= {FT_TAIL, data_i};
            enable_q <= 1'b1;
            cnt_q    <= ZERO;
            state_q  <= S_TAIL_WAIT;
          end
        end
        S_DRAIN: begin
          if (data_fire) begin
            cnt_q <= cnt_q - ONE;
            if (cnt_q == ONE) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready;
  assign data_ready_o  = data_ready;
  assign link_flit_o   = flit_q;
  assign link_enable_o = enable_q;
  assign busy_o        = (state_q != S_IDLE);
  assign err_self_o    = err_q;

`ifdef NI_TX_STATS_EN
  logic [31:0] stat_flits_q, stat_flits_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_flits_d = stat_flits_q;
    stat_stall_d = stat_stall_q;
    if (xfer && stat_flits_q != 32'hFFFF_FFFF) stat_flits_d = stat_flits_q + 32'd1;
    if (enable_q && !link_ack_i && stat_stall_q != 32'hFFFF_FFFF) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_flits_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_flits_q <= stat_flits_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_flits_o = stat_flits_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_ni_packet_tx.sv
// Directed bench for ni_packet_tx: a cycle table for the main packet shapes, plus backpressure and mid-packet reset sequences.
module tb_ni_packet_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_dst_i;
  logic [7:0]  req_len_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] data_i;
  logic [33:0] link_flit_o;
  logic        link_enable_o;
  logic        link_ack_i;
  logic        busy_o;
  logic        err_self_o;
`ifdef NI_TX_STATS_EN
  logic [31:0] stat_flits_o;
  logic [31:0] stat_stall_o;
`endif

  int tests = 0;
  int fails = 0;

  ni_packet_tx #(.X(1), .Y(1), .LEN_W(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_dst_i    (req_dst_i),
    .req_len_i    (req_len_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .link_flit_o  (link_flit_o),
    .link_enable_o(link_enable_o),
    .link_ack_i   (link_ack_i),
    .busy_o       (busy_o),
    .err_self_o   (err_self_o)
`ifdef NI_TX_STATS_EN
    ,
    .stat_flits_o (stat_flits_o),
    .stat_stall_o (stat_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rv;
    logic [7:0]  dst;
    logic [7:0]  len;
    logic        dv;
    logic [31:0] dat;
    logic        ack;
    logic        rr;
    logic        dr;
    logic        en;
    logic [33:0] flit;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [33:0] hf(input logic [7:0] d);
    return {2'b01, 24'h0, d};
  endfunction
  function automatic logic [33:0] bf(input logic [31:0] d);
    return {2'b10, d};
  endfunction
  function automatic logic [33:0] tf(input logic [31:0] d);
    return {2'b11, d};
  endfunction

  task automatic add(input logic rv, input logic [7:0] dst, input logic [7:0] len,
                     input logic dv, input logic [31:0] dat, input logic ack,
                     input logic rr, input logic dr, input logic en,
                     input logic [33:0] flit, input logic busy, input logic err);
    vec_t v;
    v.rv = rv; v.dst = dst; v.len = len; v.dv = dv; v.dat = dat; v.ack = ack;
    v.rr = rr; v.dr = dr; v.en = en; v.flit = flit; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [7:0] dst, input logic [7:0] len,
                       input logic dv, input logic [31:0] dat, input logic ack);
    req_valid_i  = rv;
    req_dst_i    = dst;
    req_len_i    = len;
    data_valid_i = dv;
    data_i       = dat;
    link_ack_i   = ack;
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    do_reset();

    // reset state, len=3 packet, len=0 packet, two back-to-back len=1, self-destined drain
    add(0, 8'h00, 0, 0, 0,            1, 0, 0, 0, 34'h0,             0, 0);
    add(1, 8'h21, 3, 0, 0,            1, 1, 0, 0, 34'h0,             0, 0);
    add(0, 8'h00, 0, 1, 32'hAAAA0001, 1, 0, 1, 1, hf(8'h21),         1, 0);
    add(0, 8'h00, 0, 1, 32'hAAAA0002, 1, 0, 1, 1, bf(32'hAAAA0001),  1, 0);
    add(0, 8'h00, 0, 1, 32'hAAAA0003, 1, 0, 1, 1, bf(32'hAAAA0002),  1, 0);
    add(0, 8'h00, 0, 0, 0,            1, 1, 0, 1, tf(32'hAAAA0003),  1, 0);
    add(0, 8'h00, 0, 0, 0,            1, 1, 0, 0, tf(32'hAAAA0003),  0, 0);
    add(1, 8'h00, 0, 0, 0,            1, 1, 0, 0, tf(32'hAAAA0003),  0, 0);
    add(0, 8'h00, 0, 1, 32'hDEAD,     1, 0, 0, 1, hf(8'h00),         1, 0);
    add(0, 8'h00, 0, 1, 32'hDEAD,     1, 1, 0, 1, tf(32'h0),         1, 0);
    add(0, 8'h00, 0, 0, 0,            1, 1, 0, 0, tf(32'h0),         0, 0);
    add(1, 8'h30, 1, 0, 0,            1, 1, 0, 0, tf(32'h0),         0, 0);
    add(1, 8'h30, 1, 1, 32'h11,       1, 0, 1, 1, hf(8'h30),         1, 0);
    add(1, 8'h30, 1, 1, 32'h22,       1, 1, 0, 1, tf(32'h11),        1, 0);
    add(0, 8'h00, 0, 1, 32'h22,       1, 0, 1, 1, hf(8'h30),         1, 0);
    add(0, 8'h00, 0, 0, 0,            1, 1, 0, 1, tf(32'h22),        1, 0);
    add(0, 8'h00, 0, 0, 0,            1, 1, 0, 0, tf(32'h22),        0, 0);
    add(1, 8'h11, 2, 0, 0,            1, 1, 0, 0, tf(32'h22),        0, 0);
    add(0, 8'h00, 0, 1, 32'h55,       1, 0, 1, 0, tf(32'h22),        1, 1);
    add(0, 8'h00, 0, 1, 32'h66,       1, 0, 1, 0, tf(32'h22),        1, 0);
    add(0, 8'h00, 0, 1, 32'h77,       1, 1, 0, 0, tf(32'h22),        0, 0);
    add(0, 8'h00, 0, 0, 0,            1, 1, 0, 0, tf(32'h22),        0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].dst, vecs[i].len, vecs[i].dv, vecs[i].dat, vecs[i].ack);
      chk($sformatf("r%0d.req_ready", i),  64'(req_ready_o),   64'(vecs[i].rr));
      chk($sformatf("r%0d.data_ready", i), 64'(data_ready_o),  64'(vecs[i].dr));
      chk($sformatf("r%0d.enable", i),     64'(link_enable_o), 64'(vecs[i].en));
      chk($sformatf("r%0d.flit", i),       64'(link_flit_o),   64'(vecs[i].flit));
      chk($sformatf("r%0d.busy", i),       64'(busy_o),        64'(vecs[i].busy));
      chk($sformatf("r%0d.err_self", i),   64'(err_self_o),    64'(vecs[i].err));
      tick();
    end

    // Backpressure: HEADER held for 5 cycles with ack=0, transfers on the 6th
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 8'h21, 2, 0, 0, 0);
    chk("bp.req_ready", 64'(req_ready_o), 64'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 32'h77, 0);
      chk($sformatf("bp.hold%0d.enable", k), 64'(link_enable_o), 64'd1);
      chk($sformatf("bp.hold%0d.flit", k),   64'(link_flit_o),   64'(hf(8'h21)));
      chk($sformatf("bp.hold%0d.dready", k), 64'(data_ready_o),  64'd0);
      tick();
    end
    drive(0, 0, 0, 1, 32'h77, 1);
    chk("bp.hdr6.flit",   64'(link_flit_o),  64'(hf(8'h21)));
    chk("bp.hdr6.dready", 64'(data_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 1, 32'h88, 1);
    chk("bp.body.flit", 64'(link_flit_o), 64'(bf(32'h77)));
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("bp.tail.flit",   64'(link_flit_o),   64'(tf(32'h88)));
    chk("bp.tail.enable", 64'(link_enable_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("bp.end.enable", 64'(link_enable_o), 64'd0);
    chk("bp.end.busy",   64'(busy_o),        64'd0);
`ifdef NI_TX_STATS_EN
    chk("bp.stat_stall", 64'(stat_stall_o), 64'd5);
    chk("bp.stat_flits", 64'(stat_flits_o), 64'd3);
`endif

    // Reset while a BODY flit is pending under backpressure
    drive(1, 8'h21, 3, 0, 0, 1);
    chk("rs.req_ready", 64'(req_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 1, 32'h99, 1);
    chk("rs.hdr.flit", 64'(link_flit_o), 64'(hf(8'h21)));
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("rs.body.flit", 64'(link_flit_o), 64'(bf(32'h99)));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("rs.after.enable", 64'(link_enable_o), 64'd0);
    chk("rs.after.busy",   64'(busy_o),        64'd0);
    chk("rs.after.rready", 64'(req_ready_o),   64'd0);
    chk("rs.after.flit",   64'(link_flit_o),   64'd0);
    tick();
    drive(1, 8'h12, 1, 0, 0, 1);
    chk("rs.new.rready", 64'(req_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 1, 32'hAB, 1);
    chk("rs.new.hdr", 64'(link_flit_o), 64'(hf(8'h12)));
    chk("rs.new.dready", 64'(data_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("rs.new.tail", 64'(link_flit_o), 64'(tf(32'hAB)));
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("rs.new.end.enable", 64'(link_enable_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
